// File: rtl/sym_stream_feeder_pkg.sv
// Shared types and symbol encodings for the matcher symbol-stream feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mfa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } feeder_state_t;

  localparam logic [1:0] SYM_A = 2'b00;
  localparam logic [1:0] SYM_C = 2'b01;
  localparam logic [1:0] SYM_G = 2'b10;
  localparam logic [1:0] SYM_T = 2'b11;

endpackage

// File: rtl/sym_stream_feeder_if.sv
// Word-write and symbol-stream handshake bundle between loader, feeder and matcher.
// Latency: n/a (wires only).
// Backpressure: wr_ready throttles the loader, sym_ready throttles the feeder.
interface sym_stream_feeder_if #(
  parameter int SYM_W  = 2,
  parameter int WORD_W = 32
);
  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  logic              sym_valid;
  logic [SYM_W-1:0]  sym_data;
  logic              sym_last;
  logic              sym_ready;

  // Feeder side: accepts words, produces symbols.
  modport slave (
    input  wr_valid, wr_data, sym_ready,
    output wr_ready, sym_valid, sym_data, sym_last
  );

  // Loader / consumer side.
  modport master (
    output wr_valid, wr_data, sym_ready,
    input  wr_ready, sym_valid, sym_data, sym_last
  );
endinterface

// File: rtl/sym_word_fifo.sv
// Synchronous word FIFO with registered not-full and empty flags, show-ahead read data.
// Latency: a word pushed at edge t is visible on pop_dat and poppable at edge t+1.
// Backpressure: push_rdy drops when full (held low during reset); a pop never frees space in the same cycle.
module sym_word_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [WORD_W-1:0] push_dat,
  output logic              push_rdy,
  input  logic              pop,
  output logic [WORD_W-1:0] pop_dat,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic [AW:0]       cnt_n;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & push_rdy;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Occupancy after this cycle's push/pop, used to register the flags.
  always_comb begin
    cnt_n = cnt;
    if (do_push && !do_pop) begin
      cnt_n = cnt + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_n = cnt - 1'b1;
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      push_rdy <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt      <= cnt_n;
      push_rdy <= (cnt_n != FULL_CNT);
      empty    <= (cnt_n == '0);
    end
  end
endmodule

// File: rtl/sym_stream_feeder.sv
// Buffers packed sequence words and serialises them LSB-first into SYM_W-bit symbols; optional FEEDER_UNDERRUN_CNT_EN adds underrun_cnt.
// Latency: start at edge t -> LOAD after t -> first sym_valid after t+1 (word already buffered); 1 symbol/cycle sustained.
// Backpressure: sym_ready or bc_mode=0 freezes the stream in place; wr_ready deasserts when the word FIFO is full.
module sym_stream_feeder
  import mfa_pkg::*;
#(
  parameter int SYM_W  = 2,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             bc_mode,
  sym_stream_feeder_if.slave bus,
  output logic             busy,
  output logic             done
`ifdef FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);
  localparam int SPW = WORD_W / SYM_W;
  localparam int IW  = (SPW > 1) ? $clog2(SPW) : 1;
  localparam logic [IW-1:0] SIDX_LAST = IW'(SPW - 1);

  feeder_state_t     state;
  feeder_state_t     state_n;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_n;
  logic [IW-1:0]     sidx;
  logic [IW-1:0]     sidx_n;
  logic [LEN_W-1:0]  remain;
  logic [LEN_W-1:0]  remain_n;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dat;
  logic              hs;

  assign push = bus.wr_valid & bus.wr_ready;

  sym_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .push_dat (bus.wr_data),
    .push_rdy (bus.wr_ready),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty)
  );

  assign bus.sym_valid = (state == SHIFT) & bc_mode;
  assign bus.sym_data  = shreg[SYM_W-1:0];
  assign bus.sym_last  = (state == SHIFT) && (remain == LEN_W'(1));
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign hs            = bus.sym_valid & bus.sym_ready;

  // Next state, FIFO pop and shifter/counter updates.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    sidx_n   = sidx;
    remain_n = remain;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (seq_len != '0) begin
            remain_n = seq_len;
            state_n  = LOAD;
          end else begin
            state_n  = FIN;
          end
        end
      end
      LOAD: begin
        // The pop ignores bc_mode so a frozen stream still has its word staged.
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_dat;
          sidx_n  = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (hs) begin
          shreg_n  = shreg >> SYM_W;
          sidx_n   = sidx + 1'b1;
          remain_n = remain - 1'b1;
          if (remain == LEN_W'(1)) begin
            // Leftover symbols of this word are dropped; buffered words stay.
            state_n = FIN;
          end else if (sidx == SIDX_LAST) begin
            if (!fifo_empty) begin
              // Back-to-back reload keeps the stream bubble-free.
              pop     = 1'b1;
              shreg_n = fifo_dat;
              sidx_n  = '0;
            end else begin
              state_n = LOAD;
            end
          end
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, shift register and counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      shreg  <= '0;
      sidx   <= '0;
      remain <= '0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      sidx   <= sidx_n;
      remain <= remain_n;
    end
  end

`ifdef FEEDER_UNDERRUN_CNT_EN
  // Saturating count of cycles spent starved for a word while enabled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      underrun_cnt <= '0;
    end else if (state == IDLE && start) begin
      underrun_cnt <= '0;
    end else if (state == LOAD && bc_mode && fifo_empty && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sym_stream_feeder.sv
// Directed bench for sym_stream_feeder with a symbol scoreboard filled on accepted word writes.
// Latency: checks start->valid, handshake->done and write->valid timing.
// Backpressure: exercises sym_ready toggling, bc_mode freeze and FIFO-full write drops.
module tb_sym_stream_feeder;
  import mfa_pkg::*;

  localparam int SPW = 16;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [15:0] seq_len;
  logic        bc_mode;
  logic        busy;
  logic        done;
`ifdef FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  sym_stream_feeder_if #(.SYM_W(2), .WORD_W(32)) bus ();

  sym_stream_feeder #(
    .SYM_W  (2),
    .WORD_W (32),
    .DEPTH  (16),
    .LEN_W  (16)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .seq_len (seq_len),
    .bc_mode (bc_mode),
    .bus     (bus),
`ifdef FEEDER_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0] exp_sym [$];
  int   n_cmp, n_bad;
  int   mrem, midx, n_hs, n_valid, first_v, last_v, cyc, done_cyc;
  logic last_valid, last_done, last_busy, last_wrdy;
  logic [1:0] last_data, held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample outputs 1 time unit after the negedge, score, move to next negedge.
  task automatic tick();
    logic [31:0] w;
    logic [1:0]  e;
    #1;
    last_valid = bus.sym_valid;
    last_done  = done;
    last_busy  = busy;
    last_data  = bus.sym_data;
    last_wrdy  = bus.wr_ready;
    if (done) done_cyc = cyc;
    if (bus.wr_valid && bus.wr_ready) begin
      w = bus.wr_data;
      for (int i = 0; i < SPW; i++) exp_sym.push_back(w[2*i +: 2]);
    end
    if (bus.sym_valid) begin
      n_valid++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (bus.sym_valid && bus.sym_ready) begin
      chk("sb_nonempty", 32'(exp_sym.size() != 0), 1);
      if (exp_sym.size() != 0) begin
        e = exp_sym.pop_front();
        chk("sym_data", 32'(bus.sym_data), 32'(e));
      end
      chk("sym_last", 32'(bus.sym_last), 32'(mrem == 1));
      if (mrem != 0) mrem--;
      midx++;
      n_hs++;
      if (mrem == 0) begin
        while (midx < SPW && exp_sym.size() != 0) begin
          void'(exp_sym.pop_front());
          midx++;
        end
      end
      if (midx == SPW) midx = 0;
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic write_word(input logic [31:0] w);
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    seq_len = 16'(len);
    mrem    = len;
    midx    = 0;
    n_hs    = 0;
    n_valid = 0;
    first_v = -1;
    last_v  = -1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    last_done = 1'b0;
    while (!last_done && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(last_done), 1);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_wr_ready"},  32'(bus.wr_ready), 0);
    chk({pfx, "_sym_valid"}, 32'(bus.sym_valid), 0);
    chk({pfx, "_sym_data"},  32'(bus.sym_data), 0);
    chk({pfx, "_sym_last"},  32'(bus.sym_last), 0);
    chk({pfx, "_busy"},      32'(busy), 0);
    chk({pfx, "_done"},      32'(done), 0);
  endtask

  task automatic release_reset(input string pfx);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk({pfx, "_wr_ready_pre_edge"}, 32'(bus.wr_ready), 0);
    @(posedge CLK);
    #1;
    chk({pfx, "_wr_ready_post_edge"}, 32'(bus.wr_ready), 1);
    @(negedge CLK);
  endtask

  initial begin
    int t0, k;
    logic [31:0] w;
    n_cmp = 0; n_bad = 0; cyc = 0; done_cyc = -1;
    mrem = 0; midx = 0; n_hs = 0; n_valid = 0; first_v = -1; last_v = -1;
    RST = 1'b0; start = 1'b0; seq_len = '0; bc_mode = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.sym_ready = 1'b1;

    // Reset values.
    repeat (2) @(negedge CLK);
    #1;
    chk_reset_outputs("rst0");
    release_reset("rst0");

    // Test 1: one word of 0,1,2,3 repeated, seq_len 16.
    w = {4{SYM_T, SYM_G, SYM_C, SYM_A}};
    write_word(w);
    t0 = cyc;
    do_start(16);
    tick();
    chk("t1_load_no_valid", 32'(last_valid), 0);
    chk("t1_load_busy", 32'(last_busy), 1);
    tick();
    chk("t1_valid_at_start_plus2", 32'(last_valid), 1);
    chk("t1_first_sym", 32'(last_data), 32'(SYM_A));
    wait_done("t1_done", 40);
    chk("t1_done_cycle", 32'(done_cyc), 32'(t0 + 18));
    chk("t1_handshakes", 32'(n_hs), 16);
    tick();
    chk("t1_done_pulse_one_cycle", 32'(last_done), 0);
    chk("t1_idle_after", 32'(last_busy), 0);

    // Test 2: three words, 40 symbols, no bubbles across word boundaries.
    for (int i = 0; i < 3; i++) write_word($urandom);
    do_start(40);
    wait_done("t2_done", 80);
    chk("t2_valid_cycles", 32'(n_valid), 40);
    chk("t2_contiguous", 32'(last_v - first_v), 39);
    chk("t2_handshakes", 32'(n_hs), 40);

    // Test 3: start with an empty FIFO, word arrives five cycles later.
    do_start(4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_starved_no_valid", 32'(last_valid), 0);
    end
    write_word($urandom);
    chk("t3_write_cycle_no_valid", 32'(last_valid), 0);
    tick();
    chk("t3_pop_cycle_no_valid", 32'(last_valid), 0);
    tick();
    chk("t3_valid_after_write", 32'(last_valid), 1);
    wait_done("t3_done", 20);
    chk("t3_handshakes", 32'(n_hs), 4);
`ifdef FEEDER_UNDERRUN_CNT_EN
    chk("t3_underrun_cnt", 32'(underrun_cnt), 5);
`endif

    // Test 4: sym_ready every other cycle, bc_mode dropped for 3 cycles mid-word.
    write_word($urandom);
    write_word($urandom);
    bus.sym_ready = 1'b0;
    do_start(20);
    k = 0;
    last_done = 1'b0;
    held = '0;
    while (!last_done && k < 200) begin
      bus.sym_ready = k[0];
      bc_mode = !(k >= 7 && k <= 9);
      tick();
      if (k == 6) held = last_data;
      if (k >= 7 && k <= 9) begin
        chk("t4_frozen_no_valid", 32'(last_valid), 0);
        chk("t4_frozen_data_steady", 32'(last_data), 32'(held));
      end
      k++;
    end
    chk("t4_done", 32'(last_done), 1);
    chk("t4_handshakes", 32'(n_hs), 20);
    chk("t4_model_remaining", 32'(mrem), 0);
    bus.sym_ready = 1'b1;
    bc_mode = 1'b1;

    // Test 5: zero-length sequence, then fill the FIFO and try writing while full.
    t0 = cyc;
    do_start(0);
    tick();
    chk("t5_done_at_start_plus1", 32'(last_done), 1);
    chk("t5_no_valid", 32'(last_valid), 0);
    chk("t5_done_cycle", 32'(done_cyc), 32'(t0 + 1));
    tick();
    chk("t5_idle_after", 32'(last_busy), 0);
    for (int i = 0; i < 16; i++) begin
      write_word($urandom);
      chk("t5_fill_wr_ready", 32'(last_wrdy), 1);
    end
    tick();
    chk("t5_full_wr_ready", 32'(last_wrdy), 0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hDEAD_BEEF;
    do_start(240);
    tick();
    chk("t5_full_pop_wr_ready", 32'(last_wrdy), 0);
    bus.wr_valid = 1'b0;
    wait_done("t5_drain_done", 300);
    chk("t5_drain_handshakes", 32'(n_hs), 240);
    do_start(16);
    wait_done("t5_last_word_done", 40);
    chk("t5_last_word_handshakes", 32'(n_hs), 16);

    // Test 6: FIFO must now be empty (dropped word absent), then reset mid-SHIFT.
    do_start(8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_empty_no_valid", 32'(last_valid), 0);
    end
    write_word($urandom);
    write_word($urandom);
    k = 0;
    while (n_hs < 3 && k < 10) begin
      tick();
      k++;
    end
    chk("t6_reached_shift", 32'(n_hs), 3);
    chk("t6_valid_before_reset", 32'(last_valid), 1);
    #2;
    RST = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    exp_sym.delete();
    mrem = 0;
    midx = 0;
    release_reset("rst1");
    do_start(4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_flushed_no_valid", 32'(last_valid), 0);
    end
    write_word($urandom);
    wait_done("t6_post_reset_done", 20);
    chk("t6_post_reset_handshakes", 32'(n_hs), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
